interfaz_mem: RTL
=================

Name: interfaz_mem

Overview:
Load/store memory interface for the multicycle RV32I core. It sits directly downstream of the mef control FSM and the address mux (sel_dir), and is started by the FSM's memory-access phase. Per access it:
- checks address alignment;
- generates byte enables and replicates store data onto a valid/ready data bus;
- sign- or zero-extends loaded data;
- returns a one-cycle listo so the FSM can leave its wait state.

Parameters:
TIEMPO_MAX, 16, bus cycles allowed without bus_listo before the access aborts with a timeout (min 2).

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (reset=0 clears all state)
inicio  in  1  one-cycle access request from mef; sampled only in REPOSO
esc  in  1  1 = store (esc_mem), 0 = load
funct3  in  3  instruction funct3: 000 lb/sb, 001 lh/sh, 010 lw/sw, 100 lbu, 101 lhu
dir  in  32  byte address from the address mux
dato_esc  in  32  store data (rs2)
listo  out  1  one-cycle pulse: access finished, ok or error
dato_lec  out  32  extended load data; holds its value until the next successful load
error_alin  out  1  pulses with listo on misalignment or illegal funct3
error_tiempo  out  1  pulses with listo on bus timeout
bus_valido  out  1  bus request
bus_esc  out  1  bus write strobe
bus_dir  out  32  word address {dir[31:2],2'b00}
bus_be  out  4  byte enables
bus_dato_esc  out  32  replicated store data
bus_listo  in  1  bus completion
bus_dato_lec  in  32  bus read word, valid when bus_listo=1

Behaviour:
- Reset, asynchronous on reset=0: state REPOSO, counter 0, all outputs 0, dato_lec=0. Reset asserted mid-access drops bus_valido immediately and produces no listo.
- States:
  - REPOSO
  - BUS
  - FIN
  - ERR_A
  - ERR_T
- REPOSO:
  - On inicio=1, register esc, funct3, dir and dato_esc.
  - Illegal funct3 (011, 11x, or 10x with esc=1), or a misaligned address, goes to ERR_A. Misaligned means half with dir[0]=1, or word with dir[1:0]!=0. No bus cycle is issued.
  - Otherwise go to BUS and clear the counter.
  - inicio=0 stays in REPOSO.
- BUS:
  - bus_valido=1; bus_esc, bus_dir, bus_be and bus_dato_esc come from the registered request and stay stable until completion.
  - bus_be: byte = 4'b0001<<dir[1:0]; half = 4'b0011<<dir[1:0]; word = 4'b1111. Loads drive the same enables.
  - bus_dato_esc: byte = {4{dato_esc[7:0]}}; half = {2{dato_esc[15:0]}}; word = dato_esc.
  - bus_listo=1 goes to FIN. On a load, dato_lec is captured that same edge: lane selected by dir[1:0], sign-extended if funct3[2]=0, zero-extended if funct3[2]=1. Stores leave dato_lec unchanged.
  - Otherwise the counter increments. When the counter equals TIEMPO_MAX-1 and bus_listo=0, go to ERR_T; bus_valido drops on entry.
  - bus_listo outside BUS is ignored.
- FIN: listo=1 for one cycle, then REPOSO.
- ERR_A: listo=1 and error_alin=1 for one cycle, then REPOSO.
- ERR_T: listo=1 and error_tiempo=1 for one cycle, then REPOSO.
- Latency: inicio at edge n gives bus_valido at n+1. With zero wait states, listo is at n+2. With k wait cycles, listo is at n+2+k. An error from REPOSO gives listo at n+1.
- inicio in any state other than REPOSO is ignored, not queued. Back-to-back accesses are possible every 3 cycles.
- All outputs are registered or decoded from the state register only, with no input-to-output combinational path.

Decomposition:
- Shared package mem_pkg:
  - state encoding (3-bit);
  - funct3 constants LB/LH/LW/LBU/LHU;
  - be and replication helper constants.
- Sub-module alineador (combinational):
  - inputs funct3, dir[1:0], dato_esc, bus_dato_lec;
  - outputs bus_be, bus_dato_esc, dato_ext, desalineado.
- The top module keeps the FSM, the request registers and the timeout counter.

Test Plan:
- Memory word 0x100 = 0x80FF7F01, zero wait, lw @0x100 -> bus_be=1111, listo at inicio+2, dato_lec=0x80FF7F01, no error.
- lb @0x101 -> be=0010, dato_lec=0x0000007F. lb @0x103 -> 0xFFFFFF80. lbu @0x103 -> 0x00000080. lh @0x102 -> 0xFFFF80FF.
- sh @0x102 with dato_esc=0x1234ABCD and bus_listo after 3 wait cycles -> bus_esc=1, be=1100, bus_dato_esc=0xABCDABCD stable for 4 cycles, listo at inicio+5, dato_lec unchanged.
- lw @0x102, and sh @0x101 -> no bus_valido; listo=error_alin=1 at inicio+1. funct3=011 -> same.
- bus_listo held 0 with TIEMPO_MAX=16 -> bus_valido high exactly 16 cycles, then listo=error_tiempo=1; second inicio pulsed during BUS is ignored.
- reset=0 asserted while in BUS -> bus_valido=0 asynchronously, no listo. After release, a lw @0x100 completes normally.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types for the load/store interface: FSM states, funct3 codes, byte-enable patterns.
// No logic of its own; the illegal-funct3 helper is pure combinational decode.
package mem_pkg;

    typedef enum logic [2:0] {
        REPOSO = 3'd0,
        BUS    = 3'd1,
        FIN    = 3'd2,
        ERR_A  = 3'd3,
        ERR_T  = 3'd4
    } estado_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    localparam logic [3:0] BE_BYTE = 4'b0001;
    localparam logic [3:0] BE_HALF = 4'b0011;
    localparam logic [3:0] BE_WORD = 4'b1111;

    // Unsigned widths only exist for loads, so 10x combined with a store is illegal.
    function automatic logic f3_ilegal(input logic esc, input logic [2:0] f3);
        return (f3 == 3'b011) || (f3[2:1] == 2'b11) || (f3[2] && esc);
    endfunction

endpackage

// File: rtl/alineador.sv
// Lane steering: byte enables, store replication, load extension and alignment check.
// Purely combinational, zero latency, no flow control of its own.
module alineador
    import mem_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [1:0]  dir,
    input  logic [31:0] dato_esc,
    input  logic [31:0] bus_dato_lec,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_dato_esc,
    output logic [31:0] dato_ext,
    output logic        desalineado
);

    logic [31:0] carril;

    always_comb begin
        bus_be       = BE_WORD;
        bus_dato_esc = dato_esc;
        dato_ext     = bus_dato_lec;
        desalineado  = 1'b0;
        carril       = bus_dato_lec >> {dir, 3'b000};
        unique case (funct3)
            F3_LB, F3_LBU: begin
                bus_be       = BE_BYTE << dir;
                bus_dato_esc = {4{dato_esc[7:0]}};
                dato_ext     = {{24{carril[7] & ~funct3[2]}}, carril[7:0]};
            end
            F3_LH, F3_LHU: begin
                bus_be       = BE_HALF << dir;
                bus_dato_esc = {2{dato_esc[15:0]}};
                dato_ext     = {{16{carril[15] & ~funct3[2]}}, carril[15:0]};
                desalineado  = dir[0];
            end
            F3_LW: begin
                desalineado  = (dir != 2'b00);
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/interfaz_mem.sv
// Load/store bus master for the multicycle core: listo 2+k cycles after inicio (1 on error).
// Waits on bus_listo with a TIEMPO_MAX-cycle timeout; inicio outside REPOSO is dropped.
module interfaz_mem
    import mem_pkg::*;
#(
    parameter int TIEMPO_MAX = 16
)
(
    input  logic        clk,
    input  logic        reset,
    input  logic        inicio,
    input  logic        esc,
    input  logic [2:0]  funct3,
    input  logic [31:0] dir,
    input  logic [31:0] dato_esc,
    output logic        listo,
    output logic [31:0] dato_lec,
    output logic        error_alin,
    output logic        error_tiempo,
    output logic        bus_valido,
    output logic        bus_esc,
    output logic [31:0] bus_dir,
    output logic [3:0]  bus_be,
    output logic [31:0] bus_dato_esc,
    input  logic        bus_listo,
    input  logic [31:0] bus_dato_lec
);

    localparam int              CW      = $clog2(TIEMPO_MAX);
    localparam logic [CW-1:0]   CNT_ULT = CW'(TIEMPO_MAX - 1);

    estado_t       estado_q, estado_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          esc_q;
    logic [2:0]    f3_q;
    logic [31:0]   dir_q, dato_q;
    logic [31:0]   dato_lec_q, dato_lec_d;

    logic          en_reposo, en_bus, captura;
    logic [2:0]    al_f3;
    logic [1:0]    al_dir;
    logic [3:0]    al_be;
    logic [31:0]   al_dato_esc, al_ext;
    logic          al_desal;

    assign en_reposo = (estado_q == REPOSO);
    assign en_bus    = (estado_q == BUS);
    assign captura   = en_reposo && inicio;

    // In REPOSO the aligner judges the incoming request; afterwards it steers the registered one.
    assign al_f3  = en_reposo ? funct3   : f3_q;
    assign al_dir = en_reposo ? dir[1:0] : dir_q[1:0];

    alineador u_alineador (
        .funct3       (al_f3),
        .dir          (al_dir),
        .dato_esc     (dato_q),
        .bus_dato_lec (bus_dato_lec),
        .bus_be       (al_be),
        .bus_dato_esc (al_dato_esc),
        .dato_ext     (al_ext),
        .desalineado  (al_desal)
    );

    always_comb begin
        estado_d   = estado_q;
        cnt_d      = cnt_q;
        dato_lec_d = dato_lec_q;
        unique case (estado_q)
            REPOSO: begin
                if (inicio) begin
                    estado_d = (al_desal || f3_ilegal(esc, funct3)) ? ERR_A : BUS;
                    cnt_d    = '0;
                end
            end
            BUS: begin
                if (bus_listo) begin
                    estado_d = FIN;
                    if (!esc_q) dato_lec_d = al_ext;
                end else if (cnt_q == CNT_ULT) begin
                    estado_d = ERR_T;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            FIN, ERR_A, ERR_T: estado_d = REPOSO;
            default:           estado_d = REPOSO;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            estado_q   <= REPOSO;
            cnt_q      <= '0;
            esc_q      <= 1'b0;
            f3_q       <= '0;
            dir_q      <= '0;
            dato_q     <= '0;
            dato_lec_q <= '0;
        end else begin
            estado_q   <= estado_d;
            cnt_q      <= cnt_d;
            dato_lec_q <= dato_lec_d;
            if (captura) begin
                esc_q  <= esc;
                f3_q   <= funct3;
                dir_q  <= dir;
                dato_q <= dato_esc;
            end
        end
    end

    assign listo        = (estado_q == FIN) || (estado_q == ERR_A) || (estado_q == ERR_T);
    assign error_alin   = (estado_q == ERR_A);
    assign error_tiempo = (estado_q == ERR_T);
    assign dato_lec     = dato_lec_q;
    assign bus_valido   = en_bus;
    assign bus_esc      = en_bus && esc_q;
    assign bus_dir      = en_bus ? {dir_q[31:2], 2'b00} : '0;
    assign bus_be       = en_bus ? al_be : '0;
    assign bus_dato_esc = en_bus ? al_dato_esc : '0;

endmodule
